// File: rtl/fifo_rd_stream.sv
// Drains an 8-bit synchronous FIFO (one-cycle read latency) into a valid/ready byte stream.
// Reads are issued only when the local buffer can absorb every byte already requested.
module fifo_rd_stream #(
  parameter int DATA_W    = 8,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              empt,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              rd_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  byte_cnt
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CB_W  = $clog2(BUF_DEPTH + 1);
  localparam int OCC_W = CB_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_V = OCC_W'(BUF_DEPTH);

  if ((BUF_DEPTH < 2) || ((BUF_DEPTH & (BUF_DEPTH - 1)) != 0)) begin : g_depth_check
    $error("fifo_rd_stream: BUF_DEPTH must be a power of two and at least 2");
  end

  logic [DATA_W-1:0] mem_q [BUF_DEPTH];
  logic [DATA_W-1:0] mem_d [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CB_W-1:0]   count_q, count_d;
  logic              inflight_q, inflight_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [OCC_W-1:0]  occ;
  logic              pop;

  // Occupancy includes the in-flight byte so a capture can never land on a full buffer.
  assign occ      = OCC_W'(count_q) + OCC_W'(inflight_q);
  assign rd_en    = ~rst & en & ~empt & (occ < DEPTH_V);
  assign m_valid  = (count_q != '0);
  assign m_data   = m_valid ? mem_q[rd_ptr_q] : '0;
  assign pop      = m_valid & m_ready;
  assign busy     = m_valid | inflight_q;
  assign byte_cnt = byte_cnt_q;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    byte_cnt_d = byte_cnt_q;
    inflight_d = rd_en;

    if (inflight_q) begin
      mem_d[wr_ptr_q] = fifo_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      byte_cnt_d = byte_cnt_q + CNT_W'(1);
    end

    case ({inflight_q, pop})
      2'b10:   count_d = count_q + CB_W'(1);
      2'b01:   count_d = count_q - CB_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      byte_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // Storage is data only; stale contents are masked by m_valid after reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side companion of the team's 8-bit synchronous FIFO: drains the FIFO through its rd_en/empt/data_out port and presents the bytes downstream on a valid/ready stream.
- Hides the FIFO's one-cycle read latency with a small internal buffer.
- Issues reads only when there is guaranteed space, so no byte is ever dropped or duplicated.
- Sits between the FIFO and any byte consumer, such as a UART TX or a packet builder.

Parameters:
- DATA_W, 8, width of FIFO data and stream data.
- BUF_DEPTH, 4, internal buffer entries; power of two, minimum 2; at least 3 is required for full throughput.
- CNT_W, 16, width of the delivered-byte counter.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  read enable; when low, no new FIFO reads are issued.
- empt  input  1  FIFO empty flag.
- fifo_data  input  DATA_W  FIFO data_out; valid one cycle after rd_en is asserted.
- rd_en  output  1  FIFO read strobe.
- m_data  output  DATA_W  stream data.
- m_valid  output  1  stream data valid.
- m_ready  input  1  downstream ready.
- busy  output  1  high when the buffer is non-empty or a read is in flight.
- byte_cnt  output  CNT_W  count of bytes delivered (transfers where m_valid and m_ready are both high).

Behaviour:
- Reset (rst high at a clock edge):
  - Buffer pointers, count, in-flight flag and byte_cnt clear to 0.
  - m_valid=0, m_data=0, busy=0.
  - rd_en is forced to 0 while rst is high.
  - Reset mid-operation discards buffered and in-flight bytes. The FIFO shares the same rst, so the system stays consistent.
- State held:
  - count: 0..BUF_DEPTH, buffer occupancy.
  - inflight: 1 bit; registered copy of the previous cycle's rd_en.
- Read issue (combinational from registered state plus the empt input):
  - rd_en = !rst && en && !empt && (count + inflight < BUF_DEPTH).
  - rd_en must never be asserted while empt=1.
- Capture:
  - When inflight=1, fifo_data is written into the buffer at wr_ptr on that edge.
  - Because of the issue rule, capture never finds the buffer full.
- Stream output:
  - m_valid = (count != 0).
  - m_data = buffer[rd_ptr], registered storage, no bypass.
  - A pop happens when m_valid && m_ready; rd_ptr advances and byte_cnt increments.
  - byte_cnt wraps modulo 2^CNT_W.
- Simultaneous capture and pop: count is unchanged and both pointers advance.
- Pointer wrap-around: modulo BUF_DEPTH.
- Latency: rd_en high in cycle N → byte captured at the end of N+1 → m_valid high in cycle N+2.
- Throughput: with BUF_DEPTH ≥ 3, FIFO non-empty and m_ready held high, one byte per cycle is sustained.
- Stream protocol:
  - Once m_valid rises, m_valid and m_data hold stable until accepted.
  - m_ready may toggle freely and is allowed to be high while m_valid=0; no effect.
- Backpressure: with m_ready low, the buffer fills to BUF_DEPTH and rd_en then stays low. The FIFO retains the remaining data.
- en deassert: no new reads are issued. An in-flight byte is still captured, and buffered bytes still drain.
- busy = (count != 0) || inflight.
- empt toggling: rd_en follows combinationally; no read is ever issued on an empty FIFO.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, en=1, empt=1 → rd_en=0, m_valid=0, byte_cnt=0, busy=0 throughout.
- Single byte: FIFO model holding {0x04}, empt drops at cycle N, m_ready=1 → rd_en high only in cycle N, m_valid high in cycle N+2 with m_data=0x04, byte_cnt=1, then empt=1 and busy=0.
- Burst: FIFO holds 0x04,0x05,0x06,0x07,0x08, m_ready=1 → stream delivers the bytes in order on 5 consecutive cycles starting 2 cycles after the first rd_en; byte_cnt=5.
- Backpressure: FIFO holds 10 bytes, m_ready=0 → exactly 4 rd_en pulses then rd_en=0, m_data stable at the first byte. Raising m_ready delivers all 10 bytes in order, none lost or duplicated.
- en gating and simultaneous events: drop en in the same cycle as an rd_en pulse, with m_ready=1 → that byte is still delivered and no further rd_en occurs. Re-raising en resumes reads; in cycles with a simultaneous capture and pop, count stays constant.
- Reset mid-burst: assert rst while 3 bytes are buffered and 1 is in flight → the next cycle shows m_valid=0, busy=0, byte_cnt=0, rd_en=0. After release, normal operation resumes with a fresh FIFO fill.
